// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic-light controller: prescaled 1 s tick, programmable phase
// durations, all-red clearance, pedestrian green truncation and yellow flash.
module traffic_phase_ctrl #(
  parameter int unsigned TW         = 10,
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEF_GREEN  = 25,
  parameter int unsigned DEF_YELLOW = 5,
  parameter int unsigned DEF_ALLRED = 2,
  parameter int unsigned PED_MIN    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [TW-1:0] cfg_data,
  input  logic          ped_req,
  input  logic          flash_mode,
  output logic          north_red_led,
  output logic          north_green_led,
  output logic          north_yellow_led,
  output logic          west_red_led,
  output logic          west_green_led,
  output logic          west_yellow_led,
  output logic [2:0]    phase,
  output logic [TW-1:0] remain
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_NG    = 3'd0,
    S_NY    = 3'd1,
    S_AR1   = 3'd2,
    S_WG    = 3'd3,
    S_WY    = 3'd4,
    S_AR2   = 3'd5,
    S_FLASH = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_remain, w_remain_nxt;
  logic          r_granted, w_granted_nxt;
  logic          r_blink, w_blink_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic [TW-1:0] r_dur_green, r_dur_yellow, r_dur_allred;

  // A programmed zero still has to show the phase for one tick.
  function automatic logic [TW-1:0] eff_dur(input logic [TW-1:0] d);
    return (d == '0) ? TW'(1) : d;
  endfunction

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dur_green  <= TW'(DEF_GREEN);
      r_dur_yellow <= TW'(DEF_YELLOW);
      r_dur_allred <= TW'(DEF_ALLRED);
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0:    r_dur_green  <= cfg_data;
        2'd1:    r_dur_yellow <= cfg_data;
        2'd2:    r_dur_allred <= cfg_data;
        default: ;
      endcase
    end
  end

  // State register together with the countdown and per-phase flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_NG;
      r_remain  <= eff_dur(TW'(DEF_GREEN));
      r_granted <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_remain  <= w_remain_nxt;
      r_granted <= w_granted_nxt;
      r_blink   <= w_blink_nxt;
    end
  end

  // Priority: flash entry/exit, then pedestrian truncation, then tick countdown.
  always_comb begin
    w_state_nxt   = r_state;
    w_remain_nxt  = r_remain;
    w_granted_nxt = r_granted;
    w_blink_nxt   = r_blink;
    if (flash_mode) begin
      w_state_nxt  = S_FLASH;
      w_remain_nxt = '0;
      if (r_state != S_FLASH) begin
        w_blink_nxt = 1'b1;
      end else if (w_tick) begin
        w_blink_nxt = ~r_blink;
      end
    end else if (r_state == S_FLASH) begin
      w_state_nxt  = S_AR2;
      w_remain_nxt = eff_dur(r_dur_allred);
    end else if ((r_state == S_NG || r_state == S_WG) && ped_req && !r_granted &&
                 (r_remain > TW'(PED_MIN))) begin
      w_remain_nxt  = TW'(PED_MIN);
      w_granted_nxt = 1'b1;
    end else if (w_tick) begin
      if (r_remain > TW'(1)) begin
        w_remain_nxt = r_remain - TW'(1);
      end else begin
        case (r_state)
          S_NG: begin
            w_state_nxt  = S_NY;
            w_remain_nxt = eff_dur(r_dur_yellow);
          end
          S_NY: begin
            w_state_nxt  = S_AR1;
            w_remain_nxt = eff_dur(r_dur_allred);
          end
          S_AR1: begin
            w_state_nxt   = S_WG;
            w_remain_nxt  = eff_dur(r_dur_green);
            w_granted_nxt = 1'b0;
          end
          S_WG: begin
            w_state_nxt  = S_WY;
            w_remain_nxt = eff_dur(r_dur_yellow);
          end
          S_WY: begin
            w_state_nxt  = S_AR2;
            w_remain_nxt = eff_dur(r_dur_allred);
          end
          default: begin
            w_state_nxt   = S_NG;
            w_remain_nxt  = eff_dur(r_dur_green);
            w_granted_nxt = 1'b0;
          end
        endcase
      end
    end
  end

  // Lamp decode from the registered state only.
  always_comb begin
    north_red_led    = 1'b0;
    north_green_led  = 1'b0;
    north_yellow_led = 1'b0;
    west_red_led     = 1'b0;
    west_green_led   = 1'b0;
    west_yellow_led  = 1'b0;
    case (r_state)
      S_NG: begin
        north_green_led = 1'b1;
        west_red_led    = 1'b1;
      end
      S_NY: begin
        north_yellow_led = 1'b1;
        west_red_led     = 1'b1;
      end
      S_WG: begin
        west_green_led = 1'b1;
        north_red_led  = 1'b1;
      end
      S_WY: begin
        west_yellow_led = 1'b1;
        north_red_led   = 1'b1;
      end
      S_FLASH: begin
        north_yellow_led = r_blink;
        west_yellow_led  = r_blink;
      end
      default: begin
        north_red_led = 1'b1;
        west_red_led  = 1'b1;
      end
    endcase
  end

  assign phase  = r_state;
  assign remain = r_remain;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: a phase-table reference model
// predicts every cycle's outputs; a separate monitor compares the DUT.
module tb_traffic_phase_ctrl;
  localparam int TW  = 10;
  localparam int TD  = 4;
  localparam int PED = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [TW-1:0] cfg_data;
  logic          ped_req;
  logic          flash_mode;
  logic          nr, ng, ny, wr, wg, wy;
  logic [2:0]    phase;
  logic [TW-1:0] remain;

  int checks   = 0;
  int failures = 0;

  traffic_phase_ctrl #(.TW(TW), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .ped_req(ped_req), .flash_mode(flash_mode),
    .north_red_led(nr), .north_green_led(ng), .north_yellow_led(ny),
    .west_red_led(wr), .west_green_led(wg), .west_yellow_led(wy),
    .phase(phase), .remain(remain)
  );

  always #5 clk = ~clk;

  // Reference model: cycle position 0..5 in a table, 6 = flash.
  int m_ph, m_rem, m_edges;
  bit m_gr, m_blink;
  int dur[3];
  logic [18:0] exp_q[$];

  function automatic logic [18:0] vec_of(int ph, int rem, bit blink);
    logic [5:0] l;
    l[5] = (ph >= 2 && ph <= 5);
    l[4] = (ph == 0);
    l[3] = (ph == 1) || (ph == 6 && blink);
    l[2] = (ph == 0 || ph == 1 || ph == 2 || ph == 5);
    l[1] = (ph == 3);
    l[0] = (ph == 4) || (ph == 6 && blink);
    return {3'(ph), 10'(rem), l};
  endfunction

  function automatic int eff(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rem = 25; m_edges = 0; m_gr = 0; m_blink = 0;
    dur[0] = 25; dur[1] = 5; dur[2] = 2;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit tick;
    tick = (m_edges % TD) == TD - 1;
    m_edges++;
    if (flash_mode) begin
      if (m_ph != 6) m_blink = 1;
      else if (tick) m_blink = !m_blink;
      m_ph = 6; m_rem = 0;
    end else if (m_ph == 6) begin
      m_ph = 5; m_rem = eff(dur[2]);
    end else if ((m_ph % 3 == 0) && ped_req && !m_gr && m_rem > PED) begin
      m_rem = PED; m_gr = 1;
    end else if (tick) begin
      if (m_rem > 1) m_rem--;
      else begin
        m_ph  = (m_ph + 1) % 6;
        m_rem = eff(dur[m_ph % 3]);
        if (m_ph % 3 == 0) m_gr = 0;
      end
    end
    if (cfg_we && cfg_addr != 2'd3) dur[cfg_addr] = int'(cfg_data);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step();
      exp_q.push_back(vec_of(m_ph, m_rem, m_blink));
    end
  end

  function automatic logic [18:0] dut_vec();
    return {phase, remain, nr, ng, ny, wr, wg, wy};
  endfunction

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act(ph=%0d rem=%0d lamps=%b) exp(ph=%0d rem=%0d lamps=%b)",
               name, $time, act[18:16], act[15:6], act[5:0], exp[18:16], exp[15:6], exp[5:0]);
    end
  endtask

  // Monitor: every clk presents a new output word.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && exp_q.size() > 0) check("cycle", dut_vec(), exp_q.pop_front());
  end

  task automatic wait_for(int ph, int rem, bit need_tick, string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_ph == ph && m_rem == rem && (!need_tick || (m_edges % TD) == TD - 1)) return;
    end
    checks++; failures++;
    $display("FAIL wait_%s timeout act(ph=%0d rem=%0d) exp(ph=%0d rem=%0d)", name, m_ph, m_rem, ph, rem);
  endtask

  task automatic write_cfg(int addr, int data);
    cfg_we = 1; cfg_addr = 2'(addr); cfg_data = TW'(data);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic pulse_ped();
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
  endtask

  localparam logic [18:0] RST_VEC = {3'd0, 10'd25, 6'b010100};

  initial begin
    model_reset();
    rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; ped_req = 0; flash_mode = 0;
    repeat (3) @(negedge clk);
    check("reset_init", dut_vec(), RST_VEC);
    rst_n = 1;

    repeat (260) @(negedge clk);

    wait_for(0, 20, 0, "ng20_cfg");
    write_cfg(0, 3);
    wait_for(3, 1, 0, "wg_short");
    write_cfg(0, 0);
    write_cfg(3, 7);
    repeat (150) @(negedge clk);
    write_cfg(0, 25);
    repeat (100) @(negedge clk);

    wait_for(0, 20, 0, "ng20_ped");
    pulse_ped();
    repeat (2) @(negedge clk);
    pulse_ped();
    wait_for(3, 4, 0, "wg4_ped");
    pulse_ped();
    wait_for(3, 10, 1, "wg10_tick");
    pulse_ped();

    wait_for(3, 15, 0, "wg15_flash");
    flash_mode = 1;
    repeat (20) @(negedge clk);
    flash_mode = 0;
    repeat (50) @(negedge clk);

    wait_for(4, 3, 0, "wy_reset");
    @(posedge clk);
    #3 rst_n = 0;
    #1 check("reset_async", dut_vec(), RST_VEC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (120) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      ped_req = ($urandom % 8) == 0;
      if (($urandom % 150) == 0) flash_mode = ~flash_mode;
      cfg_we   = ($urandom % 40) == 0;
      cfg_addr = 2'($urandom % 4);
      cfg_data = TW'($urandom % 7);
      @(negedge clk);
    end
    ped_req = 0; flash_mode = 0; cfg_we = 0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised two-road (north/west) traffic-light controller: the next generation of the fixed-timing intersection top. It adds a tick prescaler, run-time programmable green/yellow/all-red durations, an all-red clearance interval, pedestrian-request green truncation and a yellow-flash maintenance mode. It sits directly under the board top, driving the six lamp outputs and exporting phase and countdown values for a display block.

## Interface
- TW, 10: width of all duration registers and of the countdown, in seconds.
- TICK_DIV, 50000000: clk cycles per 1 s tick; must be ≥ 2.
- DEF_GREEN, 25: reset value of the green duration.
- DEF_YELLOW, 5: reset value of the yellow duration.
- DEF_ALLRED, 2: reset value of the all-red duration.
- PED_MIN, 5: remaining green, in seconds, after a granted pedestrian request.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  write strobe for a duration register.
- cfg_addr  in  2  0 green, 1 yellow, 2 all-red; 3 ignored.
- cfg_data  in  TW  duration in seconds.
- ped_req  in  1  pedestrian request, level, sampled every clk.
- flash_mode  in  1  1 = yellow-flash maintenance mode.
- north_red_led, north_green_led, north_yellow_led  out  1 each  north lamps.
- west_red_led, west_green_led, west_yellow_led  out  1 each  west lamps.
- phase  out  3  current state encoding.
- remain  out  TW  seconds left in the current phase.

## Operation
- States and encodings: NG=0, NY=1, AR1=2, WG=3, WY=4, AR2=5, FLASH=6.
- Normal cycle: NG→NY→AR1→WG→WY→AR2→NG.
- Lamp decode (combinational from the registered state):
  - NG: north green, west red.
  - NY: north yellow, west red.
  - AR1, AR2: both red.
  - WG: west green, north red.
  - WY: west yellow, north red.
  - FLASH: both yellows = blink; reds and greens off.
- Prescaler: counter 0..TICK_DIV-1. tick = 1 for one clk when the count equals TICK_DIV-1, then the counter wraps to 0. The counter free-runs in every state.
- Duration registers: cfg_we writes cfg_data to the addressed register on the next clk edge; cfg_addr=3 is ignored. A written value is used at the next entry into a phase of that type; the running countdown is not altered.
- An effective duration of 0 is treated as 1. Each phase lasts exactly max(dur,1) ticks.
- Countdown: on phase entry, remain loads the effective duration.
  - tick with remain>1: remain decrements.
  - tick with remain==1: advance to the next state and load its duration on the same edge.
- Pedestrian: in NG or WG, on a clk where ped_req=1 and remain>PED_MIN, remain loads PED_MIN. This happens at most once per green phase, tracked by a granted flag that clears on green entry.
  - If the same clk also carries a tick, the truncation wins; no decrement.
  - ped_req is ignored in every other state.
- Flash entry: flash_mode=1 moves to FLASH on the next edge from any state, aborting the current phase. blink is set to 1 and remain is held at 0.
- In FLASH: blink toggles on every tick.
- Flash exit: flash_mode=0 moves FLASH→AR2 on the next edge, loading the all-red duration, so the cycle resumes via AR2→NG.

## Timing
- Reset (async assert):
  - state NG, remain=DEF_GREEN, prescaler 0, blink 0, granted 0.
  - duration registers = defaults.
  - Outputs: north_green_led=1, west_red_led=1, all other lamps 0, phase=0.
- Reset release: the first tick occurs TICK_DIV clks after the first clk edge with rst_n high.
- Lamps, phase and remain change one clk edge after the tick or control input that causes the change. There are no combinational paths from inputs to outputs.
- A reset assertion mid-phase or mid-flash returns all state to the reset values immediately, with no clk required.
- A cfg write on the same edge as a phase entry of the same type: the entry loads the old value and the new value applies from the next entry.
- Exactly one lamp per road is lit in every non-FLASH state. Green is never lit on both roads at once.

## Test plan
- TICK_DIV=4, defaults -> NG lasts 100 clk, NY 20, AR1 8, then WG; full cycle 256 clk; remain decrements 25…1 in NG.
- Write green=3 during NG (remain 20) -> current NG completes its 25 s; the next WG lasts 3 ticks; writing 0 gives 1-tick phases.
- ped_req pulse in NG at remain=20 -> remain=5 on the next edge, NG ends 5 ticks later; a second pulse in the same NG has no effect; a pulse at remain=4 has no effect.
- flash_mode=1 mid-WG -> next edge both yellows=1, reds/greens 0, phase=6; yellows toggle every 4 clk; deassert -> AR2 for 2 ticks, then NG.
- rst_n low mid-WY for 1 clk, asynchronously -> outputs immediately return to reset values; after release, the countdown restarts at 25.
- Simultaneous ped_req and tick in WG with remain=10 -> remain=5, not 9.
